// File: rtl/slow_hold_if.sv
// Bus-side signal bundle for slow_hold: one CPU access with its device selects,
// the slow-peripheral settings, and the two slow-mode requests going back out.
interface slow_hold_if;
  logic       BACT;
  logic       IACKCS;
  logic       VIACS;
  logic       IWMCS;
  logic       SCCCS;
  logic       SCSICS;
  logic       SndCS;
  logic       SlowIACK;
  logic       SlowVIA;
  logic       SlowIWM;
  logic       SlowSCC;
  logic       SlowSCSI;
  logic       SlowSnd;
  logic       SlowClockGate;
  logic [3:0] SlowTimeout;
  logic       SlowReq;
  logic       ClockGate;

  modport master (
    output BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS,
    output SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
    output SlowClockGate, SlowTimeout,
    input  SlowReq, ClockGate
  );

  modport slave (
    input  BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS,
    input  SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
    input  SlowClockGate, SlowTimeout,
    output SlowReq, ClockGate
  );
endinterface

// File: rtl/slow_hold.sv
// Holds the accelerator in slow mode for a slow-enabled peripheral access plus a
// prescaled hold-off; retriggers cleanly on back-to-back hits.
module slow_hold #(
  parameter int unsigned TICK_DIV = 256
) (
  input  logic       CLK,
  input  logic       nPOR,
  slow_hold_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          gate_q, gate_d;
  logic          bact_q, bact_d;
  logic          slow_req_q, slow_req_d;
  logic          clock_gate_q, clock_gate_d;

  logic hit, start, trigger;

  // Selects only matter on the first cycle of an access; later changes are ignored.
  always_comb begin
    hit = (bus.IACKCS & bus.SlowIACK) | (bus.VIACS  & bus.SlowVIA)
        | (bus.IWMCS  & bus.SlowIWM)  | (bus.SCCCS  & bus.SlowSCC)
        | (bus.SCSICS & bus.SlowSCSI) | (bus.SndCS  & bus.SlowSnd);
    start   = bus.BACT & ~bact_q;
    trigger = start & hit;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    gate_d  = gate_q;
    bact_d  = bus.BACT;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = ACCESS;
          cnt_d   = bus.SlowTimeout;
          gate_d  = bus.SlowClockGate;
        end
      end
      ACCESS: begin
        if (!bus.BACT) begin
          state_d = HOLD;
          pre_d   = '0;
        end
      end
      HOLD: begin
        // A new hit outranks expiry so the request never drops between windows.
        if (trigger) begin
          state_d = ACCESS;
          cnt_d   = bus.SlowTimeout;
          gate_d  = bus.SlowClockGate;
        end else if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else if (pre_q == PRE_MAX) begin
          pre_d = '0;
          cnt_d = cnt_q - 4'd1;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    slow_req_d   = (state_d != IDLE);
    clock_gate_d = (state_d != IDLE) & gate_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nPOR) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pre_q        <= '0;
      gate_q       <= 1'b0;
      bact_q       <= 1'b0;
      slow_req_q   <= 1'b0;
      clock_gate_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      gate_q       <= gate_d;
      bact_q       <= bact_d;
      slow_req_q   <= slow_req_d;
      clock_gate_q <= clock_gate_d;
    end
  end

  assign bus.SlowReq   = slow_req_q;
  assign bus.ClockGate = clock_gate_q;

endmodule

// File: tb/tb_slow_hold.sv
// Self-checking bench for slow_hold: table-driven single accesses plus hand-written
// retrigger, back-to-back and mid-window reset sequences, checked through a scoreboard.
module tb_slow_hold;

  localparam int DIV = 4;

  logic clk  = 1'b0;
  logic n_por = 1'b0;

  always #5 clk = ~clk;

  slow_hold_if bus ();

  slow_hold #(.TICK_DIV(DIV)) dut (
    .CLK  (clk),
    .nPOR (n_por),
    .bus  (bus)
  );

  // Select/enable vector bit order: {IACK, VIA, IWM, SCC, SCSI, Snd}
  localparam logic [5:0] B_IACK = 6'b100000;
  localparam logic [5:0] B_VIA  = 6'b010000;
  localparam logic [5:0] B_IWM  = 6'b001000;
  localparam logic [5:0] B_SCC  = 6'b000100;
  localparam logic [5:0] B_SCSI = 6'b000010;
  localparam logic [5:0] B_SND  = 6'b000001;

  typedef struct {
    logic  req;
    logic  gate;
    string tag;
  } exp_t;

  typedef struct {
    logic [5:0] cs;
    logic [5:0] en;
    logic       cg;
    logic [3:0] to;
    int         len;
    logic       hit;
    string      name;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: SlowReq/ClockGate got %b required %b (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Outputs are compared mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check(mon_e.tag, {bus.SlowReq, bus.ClockGate}, {mon_e.req, mon_e.gate});
    end
  end

  task automatic set_cs(input logic [5:0] v);
    {bus.IACKCS, bus.VIACS, bus.IWMCS, bus.SCCCS, bus.SCSICS, bus.SndCS} = v;
  endtask

  task automatic set_en(input logic [5:0] v);
    {bus.SlowIACK, bus.SlowVIA, bus.SlowIWM, bus.SlowSCC, bus.SlowSCSI, bus.SlowSnd} = v;
  endtask

  // One clock cycle: drive inputs just after the edge, queue the outputs expected in this cycle.
  task automatic step_full(input logic rn, input logic bact, input logic [5:0] cs,
                           input logic er, input logic eg, input string tag);
    @(posedge clk);
    #1;
    n_por    = rn;
    bus.BACT = bact;
    set_cs(cs);
    sb_q.push_back('{req: er, gate: eg, tag: tag});
  endtask

  task automatic step(input logic bact, input logic [5:0] cs,
                      input logic er, input logic eg, input string tag);
    step_full(1'b1, bact, cs, er, eg, tag);
  endtask

  // Single access from IDLE: the request covers cycles Start+1 .. Start+len+1+to*DIV.
  task automatic run_vec(input vec_t v);
    logic g;
    g = v.hit & v.cg;
    set_en(v.en);
    bus.SlowClockGate = v.cg;
    bus.SlowTimeout   = v.to;
    step(1'b1, v.cs, 1'b0, 1'b0, {v.name, "_start"});
    for (int i = 1; i < v.len; i++)
      step(1'b1, ~v.cs, v.hit, g, {v.name, "_access"});
    for (int i = 0; i <= int'(v.to) * DIV + 1; i++)
      step(1'b0, 6'b0, v.hit, g, {v.name, "_hold"});
    step(1'b0, 6'b0, 1'b0, 1'b0, {v.name, "_end"});
    step(1'b0, 6'b0, 1'b0, 1'b0, {v.name, "_idle"});
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{cs: B_VIA,          en: B_VIA,       cg: 1'b1, to: 4'd3, len: 5, hit: 1'b1, name: "basic_via"};
    vecs[1] = '{cs: B_SCC,          en: ~B_SCC,      cg: 1'b1, to: 4'd2, len: 3, hit: 1'b0, name: "scc_disabled"};
    vecs[2] = '{cs: B_SCC,          en: B_SCC,       cg: 1'b0, to: 4'd1, len: 3, hit: 1'b1, name: "scc_nogate"};
    vecs[3] = '{cs: B_IWM,          en: B_IWM,       cg: 1'b1, to: 4'd0, len: 2, hit: 1'b1, name: "iwm_zero_to"};
    vecs[4] = '{cs: B_SND,          en: B_IACK,      cg: 1'b1, to: 4'd1, len: 2, hit: 1'b0, name: "snd_miss"};
    vecs[5] = '{cs: B_IACK | B_SND, en: B_SND,       cg: 1'b1, to: 4'd1, len: 1, hit: 1'b1, name: "multi_sel"};

    // Reset held with everything asserted.
    bus.BACT = 1'b1;
    set_cs(6'h3f);
    set_en(6'h3f);
    bus.SlowClockGate = 1'b1;
    bus.SlowTimeout   = 4'd15;
    for (int i = 0; i < 3; i++)
      step_full(1'b0, 1'b1, 6'h3f, 1'b0, 1'b0, "reset_hold");
    step_full(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, "reset_release");
    step(1'b0, 6'b0, 1'b0, 1'b0, "reset_after");

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i]);

    // Retrigger 3 cycles into HOLD, then a non-hit access inside the second hold.
    set_en(B_SCSI);
    bus.SlowClockGate = 1'b1;
    bus.SlowTimeout   = 4'd2;
    step(1'b1, B_SCSI, 1'b0, 1'b0, "retrig_start1");
    step(1'b1, B_SCSI, 1'b1, 1'b1, "retrig_access1");
    step(1'b0, 6'b0,   1'b1, 1'b1, "retrig_fall1");
    step(1'b0, 6'b0,   1'b1, 1'b1, "retrig_hold1");
    step(1'b0, 6'b0,   1'b1, 1'b1, "retrig_hold1");
    step(1'b1, B_SCSI, 1'b1, 1'b1, "retrig_start2");
    step(1'b1, B_SCSI, 1'b1, 1'b1, "retrig_access2");
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 3)
        step(1'b1, B_IACK, 1'b1, 1'b1, "retrig_nonhit");
      else
        step(1'b0, 6'b0, 1'b1, 1'b1, "retrig_hold2");
    end
    step(1'b0, 6'b0, 1'b0, 1'b0, "retrig_end");
    step(1'b0, 6'b0, 1'b0, 1'b0, "retrig_idle");

    // Back-to-back: one idle cycle between hits, retrigger lands while cnt is already 0.
    bus.SlowTimeout = 4'd0;
    step(1'b1, B_SCSI, 1'b0, 1'b0, "b2b_start1");
    step(1'b1, B_SCSI, 1'b1, 1'b1, "b2b_access1");
    step(1'b0, 6'b0,   1'b1, 1'b1, "b2b_gap");
    step(1'b1, B_SCSI, 1'b1, 1'b1, "b2b_start2");
    step(1'b0, 6'b0,   1'b1, 1'b1, "b2b_fall2");
    step(1'b0, 6'b0,   1'b1, 1'b1, "b2b_hold2");
    step(1'b0, 6'b0,   1'b0, 1'b0, "b2b_end");

    // Shortening SlowTimeout mid-HOLD must not shorten the window; reset then ends it.
    set_en(B_VIA);
    bus.SlowClockGate = 1'b1;
    bus.SlowTimeout   = 4'd15;
    step(1'b1, B_VIA, 1'b0, 1'b0, "midrst_start");
    step(1'b0, 6'b0,  1'b1, 1'b1, "midrst_fall");
    bus.SlowTimeout   = 4'd1;
    bus.SlowClockGate = 1'b0;
    for (int i = 0; i < 10; i++)
      step(1'b0, 6'b0, 1'b1, 1'b1, "midrst_settings");
    step_full(1'b0, 1'b0, 6'b0, 1'b1, 1'b1, "midrst_assert");
    step_full(1'b0, 1'b0, 6'b0, 1'b0, 1'b0, "midrst_reset");
    step_full(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, "midrst_release");
    step(1'b0, 6'b0, 1'b0, 1'b0, "midrst_idle");

    run_vec(vecs[3]);

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
